uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Byte-to-line UART transmitter for the board-to-PC link. It accepts one byte at a time from the string transmission stage through a send/busy handshake and shifts it out LSB-first on the TXD pin as an 8-bit asynchronous frame. Parity and one or two stop bits are selectable. Its `o_txd_busy` output is the busy line the upstream stage polls before advancing to the next stored character.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bit/s. `CLKS_PER_BIT` = `CLK_FREQ / BAUD_RATE`, using integer truncation.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal values are 1 or 2.

Ports:
- `i_Clk`, input, 1: system clock. One clock domain; all logic on the rising edge.
- `i_Rst`, input, 1: reset. Synchronous, active-high.
- `i_tx_data`, input, 8: byte to send. Sampled only on an accept cycle.
- `i_send`, input, 1: send request. Level, not a pulse; upstream may hold it high across many frames.
- `o_txd`, output, 1: serial line. Idles high.
- `o_txd_busy`, output, 1: high while a frame is in flight.
- `o_tx_done`, output, 1: one-cycle pulse when a frame's last stop bit completes.

## Operation
- Accept condition: `i_send && !o_txd_busy` at a rising edge. On accept:
  - latch `i_tx_data` into the shift register;
  - compute the parity bit (odd: `~^data`; even: `^data`);
  - enter START.
- State machine:
  - IDLE → START on accept.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA runs 8 bit-periods, bit 0 first. It then goes to PARITY if `PARITY != 0`, otherwise to STOP.
  - PARITY → STOP after one bit-period.
  - STOP runs `STOP_BITS` bit-periods, then returns to IDLE.
- `o_txd` per state: IDLE = 1, START = 0, DATA = current shift LSB, PARITY = parity bit, STOP = 1.
- `o_txd` is registered, so it is glitch-free.
- Counters:
  - The baud counter counts 0..`CLKS_PER_BIT`-1 with width `$clog2(CLKS_PER_BIT)`. It reloads to 0 on every state entry.
  - The bit counter is 3 bits for DATA and 1 bit for STOP.
- `o_txd_busy` is high in every state except IDLE.
- `i_send` while busy is ignored; there is no queue. `i_tx_data` changes while busy have no effect.
- Reset mid-frame: the frame is aborted. On the next edge the line returns high and the block is in IDLE. No `o_tx_done` pulse is produced.
- `i_Rst` and accept in the same cycle: reset wins and nothing is latched.

## Timing
- Reset values: `o_txd` = 1, `o_txd_busy` = 0, `o_tx_done` = 0, state = IDLE, counters = 0.
- Accept at edge k:
  - `o_txd` falls to 0 and `o_txd_busy` rises at edge k+1;
  - the start bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length F = (1 + 8 + (`PARITY` != 0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles, measured from the start-bit edge.
- At edge k+1+F:
  - state = IDLE, `o_txd_busy` = 0;
  - `o_tx_done` = 1 for that single cycle.
- Because busy is low in that cycle, an `i_send` held high is accepted there. The next start bit begins at edge k+2+F, giving exactly one idle-high cycle between frames.
- Busy is registered and rises the cycle after accept. This guarantees a single accept per frame when `i_send` is a level.
- Elaboration checks: `CLKS_PER_BIT` ≥ 2; `STOP_BITS` in {1, 2}; `PARITY` in {0, 1, 2}.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - default `CLK_FREQ` / `BAUD_RATE`;
  - function `clks_per_bit()`.
- Sub-module `uart_baud_tick`: parameterised counter with a synchronous restart input and a one-cycle `o_tick` output at count `CLKS_PER_BIT`-1. The upstream receiver reuses it later, sampling at half-period.
- Top level holds the FSM, shift register, parity and output registers.

## Test plan
Bench parameters: `CLK_FREQ` = 160, `BAUD_RATE` = 10, so `CLKS_PER_BIT` = 16.
- Reset: `i_Rst` high 3 cycles → `o_txd` = 1, `o_txd_busy` = 0, `o_tx_done` = 0; all hold for 50 idle cycles.
- 0x41, no parity, 1 stop, single-cycle `i_send` → line reads 0, then 1,0,0,0,0,0,1,0, then 1, each bit 16 cycles; busy high for 160 cycles; `o_tx_done` pulses once.
- 0x41 with `PARITY` = 2 (even) → parity bit 0; with `PARITY` = 1 (odd) → 1. `STOP_BITS` = 2 → frame is 192 cycles.
- `i_send` held high with 0x48 then 0x69 ('H', 'i') presented on `o_tx_done` → exactly two frames, one idle cycle between them, no duplicate frame.
- Change `i_tx_data` to 0xFF and pulse `i_send` mid-frame → current frame unchanged and the request is not sent.
- Assert `i_Rst` during DATA bit 4 → `o_txd` = 1 and busy = 0 on the next edge; no `o_tx_done`; the next accepted frame is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 115_200;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: ticks for one cycle at count CLKS_PER_BIT-1, restartable.
`timescale 1ns/1ps
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign o_tick = (count == LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_restart || o_tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: send/busy handshake, LSB-first frame, optional parity,
// one or two stop bits, registered glitch-free line output.
`timescale 1ns/1ps
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD_RATE = DEF_BAUD_RATE,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_send,
    output logic       o_txd,
    output logic       o_txd_busy,
    output logic       o_tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("PARITY must be 0, 1 or 2");
    end

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic       par_bit, par_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       stop_cnt, stop_cnt_n;
    logic       txd_n, done_n;
    logic       tick, accept;

    assign accept = i_send && !o_txd_busy;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_restart(state == S_IDLE),
        .o_tick   (tick)
    );

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        par_n      = par_bit;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        done_n     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_START;
                    shift_n = i_tx_data;
                    par_n   = (PARITY == PAR_ODD) ? ~^i_tx_data : ^i_tx_data;
                end
            end
            S_START: begin
                if (tick) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n  = '0;
                        stop_cnt_n = 1'b0;
                        state_n    = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_n    = S_STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Line level follows the state being entered so it is registered.
        unique case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = shift_n[0];
            S_PARITY: txd_n = par_n;
            default:  txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= S_IDLE;
            shift      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            o_txd      <= 1'b1;
            o_txd_busy <= 1'b0;
            o_tx_done  <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            par_bit    <= par_n;
            bit_cnt    <= bit_cnt_n;
            stop_cnt   <= stop_cnt_n;
            o_txd      <= txd_n;
            o_txd_busy <= (state_n != S_IDLE);
            o_tx_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parity/stop configurations checked
// cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst  [3];
    logic       send [3];
    logic [7:0] data [3];
    logic       txd  [3];
    logic       busy [3];
    logic       done [3];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_serializer #(
            .CLK_FREQ (160),
            .BAUD_RATE(10),
            .PARITY   (g == 0 ? 0 : (g == 1 ? 2 : 1)),
            .STOP_BITS(g == 2 ? 2 : 1)
        ) u_dut (
            .i_Clk     (clk),
            .i_Rst     (rst[g]),
            .i_tx_data (data[g]),
            .i_send    (send[g]),
            .o_txd     (txd[g]),
            .o_txd_busy(busy[g]),
            .o_tx_done (done[g])
        );
    end

    function automatic int par_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic int stops_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int d);
        return (9 + ((par_of(d) != 0) ? 1 : 0) + stops_of(d)) * CPB;
    endfunction

    // Expected line level c cycles after the start bit begins.
    function automatic logic exp_line(input int d, input logic [7:0] b, input int c);
        int i;
        int ones;
        i = c / CPB;
        ones = $countones(b);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (par_of(d) == 1 && i == 9) return (ones % 2 == 0);
        if (par_of(d) == 2 && i == 9) return (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] outs(input int d);
        return {txd[d], busy[d], done[d]};
    endfunction

    task automatic idle(input int d, input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk(tag, outs(d), 3'b100);
        end
    endtask

    task automatic start_frame(input int d, input logic [7:0] b, input bit hold);
        @(negedge clk);
        data[d] = b;
        send[d] = 1'b1;
        @(negedge clk);
        if (!hold) send[d] = 1'b0;
    endtask

    // Called in cycle 0 of a frame; returns in the done cycle or after abort.
    task automatic frame_body(input int d, input logic [7:0] b,
                              input int abort_at, input int inject_at);
        for (int c = 0; c < frame_len(d); c++) begin
            chk("frame", outs(d), {exp_line(d, b, c), 1'b1, 1'b0});
            if (c == inject_at) begin
                data[d] = 8'hFF;
                send[d] = 1'b1;
            end
            if (inject_at >= 0 && c == inject_at + 1) begin
                send[d] = 1'b0;
                data[d] = 8'h00;
            end
            if (c == abort_at) begin
                rst[d] = 1'b1;
                @(negedge clk);
                chk("abort", outs(d), 3'b100);
                rst[d] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("done", outs(d), 3'b101);
    endtask

    initial begin
        logic [7:0] b;
        for (int d = 0; d < 3; d++) begin
            rst[d]  = 1'b1;
            send[d] = 1'b0;
            data[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset", outs(d), 3'b100);
            rst[d] = 1'b0;
        end
        repeat (50) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk("reset_idle", outs(d), 3'b100);
        end

        // 0x41 on each configuration: none/1, even/1, odd/2
        for (int d = 0; d < 3; d++) begin
            start_frame(d, 8'h41, 1'b0);
            frame_body(d, 8'h41, -1, -1);
            idle(d, 5, "post_done");
        end

        // Level-held send: 'H' then 'i' back to back, no duplicate
        for (int d = 0; d < 3; d += 2) begin
            start_frame(d, 8'h48, 1'b1);
            frame_body(d, 8'h48, -1, -1);
            data[d] = 8'h69;
            @(negedge clk);
            send[d] = 1'b0;
            frame_body(d, 8'h69, -1, -1);
            idle(d, 40, "no_dup");
        end

        // Request while busy is ignored
        start_frame(1, 8'h41, 1'b0);
        frame_body(1, 8'h41, -1, 40);
        idle(1, 30, "ignored_req");

        // Reset during DATA bit 4, then a clean frame
        start_frame(0, 8'hA5, 1'b0);
        frame_body(0, 8'hA5, CPB + 4 * CPB + 8, -1);
        idle(0, 20, "post_abort");
        start_frame(0, 8'h3C, 1'b0);
        frame_body(0, 8'h3C, -1, -1);
        idle(0, 5, "post_abort_frame");

        // Reset and request in the same cycle: reset wins
        @(negedge clk);
        rst[0]  = 1'b1;
        send[0] = 1'b1;
        data[0] = 8'h77;
        @(negedge clk);
        chk("rst_wins", outs(0), 3'b100);
        rst[0]  = 1'b0;
        send[0] = 1'b0;
        idle(0, 40, "rst_wins_idle");

        // Randomized bytes and gaps
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 5; k++) begin
                b = 8'($urandom);
                idle(d, $urandom_range(0, 10), "rand_gap");
                start_frame(d, b, 1'b0);
                frame_body(d, b, -1, -1);
            end
            idle(d, 3, "rand_tail");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
